// File: rtl/seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and default widths.
package seq_pkg;

  localparam int N_DEF = 4;
  localparam int R_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_step_counter.sv
// N-bit step counter with clear, load-zero and enable; clear has the highest priority.
module seq_step_counter #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load_zero,
  input  logic         i_en,
  output logic [N-1:0] o_count
);

  // count register: clear > load-zero > increment (modulo 2^N)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_load_zero) begin
      o_count <= '0;
    end else if (i_en) begin
      o_count <= o_count + {{(N-1){1'b0}}, 1'b1};
    end else begin
      o_count <= o_count;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Multi-pass counter sequencer: counts 0..limit for repeats+1 passes, with pause and abort.
module counter_sequencer
  import seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         pause,
  input  logic [N-1:0] limit,
  input  logic [R-1:0] repeats,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         wrap,
  output logic         done
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic [N-1:0] r_limit;
  logic [R-1:0] r_repeats;
  logic [R-1:0] r_pass;
  logic         r_busy;
  logic         r_wrap;
  logic         r_done;

  logic w_clr, w_load_zero, w_en;
  logic w_wrap_d, w_done_d, w_pass_inc, w_capture;
  logic w_at_limit, w_term;

  assign w_at_limit = (count == r_limit);
  // r_pass counts completed passes, so the final pass is the one where it equals repeats
  assign w_term     = w_at_limit && (r_pass == r_repeats);

  seq_step_counter #(.N(N)) u_step (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_clr       (w_clr),
    .i_load_zero (w_load_zero),
    .i_en        (w_en),
    .o_count     (count)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic: abort > pause > count/terminal
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
        else       w_next = ST_IDLE;
      end
      ST_RUN: begin
        if (abort)       w_next = ST_IDLE;
        else if (pause)  w_next = ST_PAUSE;
        else if (w_term) w_next = ST_DONE;
        else             w_next = ST_RUN;
      end
      ST_PAUSE: begin
        if (abort)       w_next = ST_IDLE;
        else if (!pause) w_next = ST_RUN;
        else             w_next = ST_PAUSE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // datapath controls and next values of the pulse outputs
  always_comb begin
    w_clr       = 1'b0;
    w_load_zero = 1'b0;
    w_en        = 1'b0;
    w_wrap_d    = 1'b0;
    w_done_d    = 1'b0;
    w_pass_inc  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clr     = 1'b1;
        w_capture = start;
      end
      ST_RUN: begin
        if (abort) begin
          w_clr = 1'b1;
        end else if (pause) begin
          w_en = 1'b0;
        end else if (w_at_limit) begin
          w_load_zero = 1'b1;
          w_wrap_d    = 1'b1;
          w_pass_inc  = 1'b1;
          w_done_d    = w_term;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (abort) w_clr = 1'b1;
        else       w_clr = 1'b0;
      end
      ST_DONE: w_clr = 1'b1;
      default: w_clr = 1'b1;
    endcase
  end

  // captured parameters, pass counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_limit   <= '0;
      r_repeats <= '0;
      r_pass    <= '0;
      r_busy    <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_limit   <= limit;
        r_repeats <= repeats;
        r_pass    <= '0;
      end else if (w_pass_inc) begin
        r_pass    <= r_pass + {{(R-1){1'b0}}, 1'b1};
      end else begin
        r_pass    <= r_pass;
      end
      r_busy <= (w_next == ST_RUN) || (w_next == ST_PAUSE);
      r_wrap <= w_wrap_d;
      r_done <= w_done_d;
    end
  end

  assign busy = r_busy;
  assign wrap = r_wrap;
  assign done = r_done;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed table-driven bench for counter_sequencer plus hand sequences for wrap-at-max and reset.
module tb_counter_sequencer;

  localparam int N = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         pause = 1'b0;
  logic [N-1:0] limit = '0;
  logic [R-1:0] repeats = '0;
  logic [N-1:0] count;
  logic         busy, wrap, done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       st, ab, pa;
    logic [3:0] lim, rep, ec;
    logic       eb, ew, ed;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  counter_sequencer #(.N(N), .R(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pause   (pause),
    .limit   (limit),
    .repeats (repeats),
    .count   (count),
    .busy    (busy),
    .wrap    (wrap),
    .done    (done)
  );

  task automatic chk(input string nm, input int idx, input logic [3:0] ec,
                     input logic eb, input logic ew, input logic ed);
    n_cmp++;
    if (count !== ec || busy !== eb || wrap !== ew || done !== ed) begin
      n_err++;
      $display("FAIL %s[%0d]: got count=%0d busy=%b wrap=%b done=%b, expected count=%0d busy=%b wrap=%b done=%b",
               nm, idx, count, busy, wrap, done, ec, eb, ew, ed);
    end
  endtask

  task automatic add(input logic st, input logic ab, input logic pa,
                     input logic [3:0] lim, input logic [3:0] rep, input logic [3:0] ec,
                     input logic eb, input logic ew, input logic ed);
    vec_t v;
    v.st = st; v.ab = ab; v.pa = pa; v.lim = lim; v.rep = rep;
    v.ec = ec; v.eb = eb; v.ew = ew; v.ed = ed;
    vq.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // limit=3, repeats=1; a start with limit 9 mid-run and a start during DONE are both ignored
    add(1'b1,1'b0,1'b0, 4'd3,4'd1, 4'd0, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd3,4'd1, 4'd1, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd3,4'd1, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd3,4'd1, 4'd3, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd3,4'd1, 4'd0, 1'b1,1'b1,1'b0);
    add(1'b1,1'b0,1'b0, 4'd9,4'd0, 4'd1, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd9,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd9,4'd0, 4'd3, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd9,4'd0, 4'd0, 1'b0,1'b1,1'b1);
    add(1'b1,1'b0,1'b0, 4'd3,4'd1, 4'd0, 1'b0,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd3,4'd1, 4'd0, 1'b0,1'b0,1'b0);
    // limit=0, repeats=2: three back-to-back wraps, done with the third
    add(1'b1,1'b0,1'b0, 4'd0,4'd2, 4'd0, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd0,4'd2, 4'd0, 1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0, 4'd0,4'd2, 4'd0, 1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0, 4'd0,4'd2, 4'd0, 1'b0,1'b1,1'b1);
    add(1'b0,1'b0,1'b0, 4'd0,4'd2, 4'd0, 1'b0,1'b0,1'b0);
    // limit=7, abort at count 4, then a fresh run with limit=2
    add(1'b1,1'b0,1'b0, 4'd7,4'd0, 4'd0, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd7,4'd0, 4'd1, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd7,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd7,4'd0, 4'd3, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd7,4'd0, 4'd4, 1'b1,1'b0,1'b0);
    add(1'b0,1'b1,1'b0, 4'd7,4'd0, 4'd0, 1'b0,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd7,4'd0, 4'd0, 1'b0,1'b0,1'b0);
    add(1'b1,1'b0,1'b0, 4'd2,4'd0, 4'd0, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd2,4'd0, 4'd1, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd2,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd2,4'd0, 4'd0, 1'b0,1'b1,1'b1);
    add(1'b0,1'b0,1'b0, 4'd2,4'd0, 4'd0, 1'b0,1'b0,1'b0);
    // limit=5, pause held three edges at count 2: count stays 2 for four extra cycles
    add(1'b1,1'b0,1'b0, 4'd5,4'd0, 4'd0, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd1, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b1, 4'd5,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b1, 4'd5,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b1, 4'd5,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd2, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd3, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd4, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd5, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd0, 1'b0,1'b1,1'b1);
    add(1'b0,1'b0,1'b0, 4'd5,4'd0, 4'd0, 1'b0,1'b0,1'b0);
    // abort wins over pause while paused; limit reached with pause high does not wrap
    add(1'b1,1'b0,1'b0, 4'd1,4'd0, 4'd0, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd1,4'd0, 4'd1, 1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b1, 4'd1,4'd0, 4'd1, 1'b1,1'b0,1'b0);
    add(1'b0,1'b1,1'b1, 4'd1,4'd0, 4'd0, 1'b0,1'b0,1'b0);
    add(1'b0,1'b0,1'b0, 4'd1,4'd0, 4'd0, 1'b0,1'b0,1'b0);

    #1 rst = 1'b0;
    #10;
    chk("reset_hold", 0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    chk("idle_after_reset", 0, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      start   = vq[i].st;
      abort   = vq[i].ab;
      pause   = vq[i].pa;
      limit   = vq[i].lim;
      repeats = vq[i].rep;
      tick;
      chk("vec", i, vq[i].ec, vq[i].eb, vq[i].ew, vq[i].ed);
    end
    start = 1'b0; abort = 1'b0; pause = 1'b0;

    // limit = 2^N-1 runs through every value and wraps to 0
    start = 1'b1; limit = 4'd15; repeats = 4'd0;
    tick;
    chk("max_start", 0, 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick;
      chk("max_count", i, 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick;
    chk("max_wrap", 0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick;
    chk("max_idle", 0, 4'd0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between edges at count 2 clears outputs at once, no done afterwards
    start = 1'b1; limit = 4'd5; repeats = 4'd0;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("pre_reset", 0, 4'd2, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", 0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_reset_idle", i, 4'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
